// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: central pipeline sequencer for the 5-stage RV32IM core.
// Arbitrates EX redirects, load-use hazards and mul/div busy, and drives the
// PC select/target plus the pc, fe2dec and dec2ex write enables.
// Optional macro PIPE_SEQ_CTRL_PERF_EN adds saturating redirect/stall counters;
// without it both counter ports read zero and no counter flops exist.
module pipe_seq_ctrl #(
  parameter int W            = 32,
  parameter int FLUSH_CYCLES = 2,   // legal range 1..7
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_req,
  input  logic [W-1:0]      redirect_tgt,
  input  logic              ld_use_haz,
  input  logic              md_busy,
  output logic              pc_sel,
  output logic [W-1:0]      pc_tgt,
  output logic              pc_we,
  output logic              fe_we,
  output logic              dec_we,
  output logic              ex_hold,
  output logic              flush,
  output logic [1:0]        state,
  output logic [PERF_W-1:0] redirect_cnt,
  output logic [PERF_W-1:0] stall_cnt
);

  // Flush counter only ever needs to hold FLUSH_CYCLES-1, at most 6.
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FLUSH  = 2'b01,
    ST_MDWAIT = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             redirect_accept;

  // A redirect is only honoured in RUN; during FLUSH the EX contents are wrong-path.
  assign redirect_accept = (state_q == ST_RUN) && redirect_req;

  assign state = state_q;

  // State register; reset discards any pending flush or stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; in RUN a redirect beats md_busy, which beats load-use.
  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN: begin
        if (redirect_req) begin
          state_d = ST_FLUSH;
        end else if (md_busy) begin
          state_d = ST_MDWAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_MDWAIT: begin
        if (md_busy) begin
          state_d = ST_MDWAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output decode; a cleared dec_we loads a NOP into dec2ex.
  always_comb begin
    pc_we   = 1'b1;
    fe_we   = 1'b1;
    dec_we  = 1'b1;
    ex_hold = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect_req) begin
          dec_we = 1'b0;
          flush  = 1'b1;
        end else if (md_busy) begin
          pc_we   = 1'b0;
          fe_we   = 1'b0;
          dec_we  = 1'b0;
          ex_hold = 1'b1;
        end else if (ld_use_haz) begin
          pc_we  = 1'b0;
          fe_we  = 1'b0;
          dec_we = 1'b0;
        end
      end
      ST_FLUSH: begin
        dec_we = 1'b0;
        flush  = 1'b1;
      end
      ST_MDWAIT: begin
        if (md_busy) begin
          pc_we   = 1'b0;
          fe_we   = 1'b0;
          dec_we  = 1'b0;
          ex_hold = 1'b1;
        end
      end
      default: begin
        pc_we  = 1'b1;
        fe_we  = 1'b1;
        dec_we = 1'b1;
      end
    endcase
  end

  // Flush counter: loaded on an accepted redirect, counts down while flushing.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt_q <= '0;
    end else if (redirect_accept) begin
      flush_cnt_q <= CNT_W'(FLUSH_CYCLES - 1);
    end else if ((state_q == ST_FLUSH) && (flush_cnt_q != '0)) begin
      flush_cnt_q <= flush_cnt_q - 1'b1;
    end
  end

  // Registered PC redirect: pc_sel pulses for one cycle, pc_tgt holds until the next redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_sel <= 1'b0;
      pc_tgt <= '0;
    end else begin
      pc_sel <= redirect_accept;
      if (redirect_accept) begin
        pc_tgt <= redirect_tgt;
      end
    end
  end

`ifdef PIPE_SEQ_CTRL_PERF_EN
  logic [PERF_W-1:0] redirect_cnt_q;
  logic [PERF_W-1:0] stall_cnt_q;
  logic              ld_stall;

  // A load-use stall only counts when neither higher-priority source is active in RUN.
  assign ld_stall = (state_q == ST_RUN) && !redirect_req && !md_busy && ld_use_haz;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (redirect_accept && (redirect_cnt_q != '1)) begin
        redirect_cnt_q <= redirect_cnt_q + 1'b1;
      end
      if ((ld_stall || ex_hold) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`else
  assign redirect_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed testbench for pipe_seq_ctrl with default parameters (FLUSH_CYCLES=2).
// Counter expectations follow PIPE_SEQ_CTRL_PERF_EN (zero when undefined).
module tb_pipe_seq_ctrl;

  localparam int W      = 32;
  localparam int PERF_W = 16;

`ifdef PIPE_SEQ_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              redirect_req;
  logic [W-1:0]      redirect_tgt;
  logic              ld_use_haz;
  logic              md_busy;
  logic              pc_sel;
  logic [W-1:0]      pc_tgt;
  logic              pc_we;
  logic              fe_we;
  logic              dec_we;
  logic              ex_hold;
  logic              flush;
  logic [1:0]        state;
  logic [PERF_W-1:0] redirect_cnt;
  logic [PERF_W-1:0] stall_cnt;

  int checks;
  int failures;

  pipe_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .redirect_req (redirect_req),
    .redirect_tgt (redirect_tgt),
    .ld_use_haz   (ld_use_haz),
    .md_busy      (md_busy),
    .pc_sel       (pc_sel),
    .pc_tgt       (pc_tgt),
    .pc_we        (pc_we),
    .fe_we        (fe_we),
    .dec_we       (dec_we),
    .ex_hold      (ex_hold),
    .flush        (flush),
    .state        (state),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt)
  );

  // 10 ns core clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next cycle, drive its inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic rst, input logic rr, input logic [W-1:0] tgt,
                               input logic lu, input logic mb);
    @(posedge clk);
    #2;
    reset        = rst;
    redirect_req = rr;
    redirect_tgt = tgt;
    ld_use_haz   = lu;
    md_busy      = mb;
    #1;
  endtask

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Checks the enables as {pc_we, fe_we, dec_we} plus ex_hold, flush and state.
  task automatic checkCtl(input string tag, input logic [2:0] we, input logic hold,
                          input logic fl, input logic [1:0] st);
    checkOutput({tag, "_we"}, 32'({pc_we, fe_we, dec_we}), 32'(we));
    checkOutput({tag, "_hold"}, 32'(ex_hold), 32'(hold));
    checkOutput({tag, "_flush"}, 32'(flush), 32'(fl));
    checkOutput({tag, "_state"}, 32'(state), 32'(st));
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    redirect_req = 1'b0;
    redirect_tgt = '0;
    ld_use_haz   = 1'b0;
    md_busy      = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkCtl("rst", 3'b111, 1'b0, 1'b0, 2'b00);
    checkOutput("rst_pc_sel", 32'(pc_sel), 32'd0);
    checkOutput("rst_pc_tgt", pc_tgt, 32'h0);
    checkOutput("rst_redir_cnt", 32'(redirect_cnt), 32'd0);
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    $display("[TB] idle run");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkCtl("idle", 3'b111, 1'b0, 1'b0, 2'b00);
      checkOutput("idle_pc_sel", 32'(pc_sel), 32'd0);
    end

    $display("[TB] redirect");
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);   // T
    checkCtl("redir_t0", 3'b110, 1'b0, 1'b1, 2'b00);
    checkOutput("redir_t0_pc_sel", 32'(pc_sel), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);           // T+1
    checkCtl("redir_t1", 3'b110, 1'b0, 1'b1, 2'b01);
    checkOutput("redir_t1_pc_sel", 32'(pc_sel), 32'd1);
    checkOutput("redir_t1_pc_tgt", pc_tgt, 32'h0000_0100);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);           // T+2
    checkCtl("redir_t2", 3'b110, 1'b0, 1'b1, 2'b01);
    checkOutput("redir_t2_pc_sel", 32'(pc_sel), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);           // T+3
    checkCtl("redir_t3", 3'b111, 1'b0, 1'b0, 2'b00);
    checkOutput("redir_t3_pc_tgt", pc_tgt, 32'h0000_0100);
    checkOutput("redir_cnt1", 32'(redirect_cnt), PERF ? 32'd1 : 32'd0);

    $display("[TB] md_busy 4 cycles");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkCtl("md_t0", 3'b000, 1'b1, 1'b0, 2'b00);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      checkCtl("md_wait", 3'b000, 1'b1, 1'b0, 2'b10);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);           // T+4
    checkCtl("md_t4", 3'b111, 1'b0, 1'b0, 2'b10);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);           // T+5
    checkCtl("md_t5", 3'b111, 1'b0, 1'b0, 2'b00);
    checkOutput("md_stall_cnt", 32'(stall_cnt), PERF ? 32'd4 : 32'd0);

    $display("[TB] redirect with md_busy");
    applyStimulus(1'b0, 1'b1, 32'h0000_2000, 1'b0, 1'b1);   // T
    checkCtl("rm_t0", 3'b110, 1'b0, 1'b1, 2'b00);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);           // T+1
    checkCtl("rm_t1", 3'b110, 1'b0, 1'b1, 2'b01);
    checkOutput("rm_t1_pc_sel", 32'(pc_sel), 32'd1);
    checkOutput("rm_t1_pc_tgt", pc_tgt, 32'h0000_2000);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);           // T+2
    checkCtl("rm_t2", 3'b110, 1'b0, 1'b1, 2'b01);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);           // T+3
    checkCtl("rm_t3", 3'b000, 1'b1, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);           // T+4
    checkCtl("rm_t4", 3'b000, 1'b1, 1'b0, 2'b10);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);           // T+5
    checkCtl("rm_t5", 3'b111, 1'b0, 1'b0, 2'b10);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);           // T+6
    checkCtl("rm_t6", 3'b111, 1'b0, 1'b0, 2'b00);
    checkOutput("rm_redir_cnt", 32'(redirect_cnt), PERF ? 32'd2 : 32'd0);
    checkOutput("rm_stall_cnt", 32'(stall_cnt), PERF ? 32'd6 : 32'd0);

    $display("[TB] load-use then ignored redirect");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkCtl("lu_bubble", 3'b000, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkCtl("lu_after", 3'b111, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0);   // T
    checkCtl("ig_t0", 3'b110, 1'b0, 1'b1, 2'b00);
    applyStimulus(1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b0);   // T+1, ignored
    checkCtl("ig_t1", 3'b110, 1'b0, 1'b1, 2'b01);
    checkOutput("ig_t1_pc_sel", 32'(pc_sel), 32'd1);
    checkOutput("ig_t1_pc_tgt", pc_tgt, 32'h0000_0300);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);           // T+2
    checkCtl("ig_t2", 3'b110, 1'b0, 1'b1, 2'b01);
    checkOutput("ig_t2_pc_sel", 32'(pc_sel), 32'd0);
    checkOutput("ig_t2_pc_tgt", pc_tgt, 32'h0000_0300);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);           // T+3
    checkCtl("ig_t3", 3'b111, 1'b0, 1'b0, 2'b00);
    checkOutput("ig_t3_pc_sel", 32'(pc_sel), 32'd0);
    checkOutput("ig_t3_pc_tgt", pc_tgt, 32'h0000_0300);

    $display("[TB] consecutive load-use and md_busy priority");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkCtl("lu2_a", 3'b000, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkCtl("lu2_b", 3'b000, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checkCtl("mdlu_t0", 3'b000, 1'b1, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkCtl("mdlu_t1", 3'b111, 1'b0, 1'b0, 2'b10);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkCtl("mdlu_t2", 3'b111, 1'b0, 1'b0, 2'b00);
    checkOutput("cnt_redir_total", 32'(redirect_cnt), PERF ? 32'd3 : 32'd0);
    checkOutput("cnt_stall_total", 32'(stall_cnt), PERF ? 32'd10 : 32'd0);

    $display("[TB] reset during flush");
    applyStimulus(1'b0, 1'b1, 32'h0000_0500, 1'b0, 1'b0);   // T
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);           // T+1, reset asserted
    checkCtl("rf_t1", 3'b110, 1'b0, 1'b1, 2'b01);
    checkOutput("rf_t1_pc_sel", 32'(pc_sel), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);           // T+2
    checkCtl("rf_t2", 3'b111, 1'b0, 1'b0, 2'b00);
    checkOutput("rf_t2_pc_sel", 32'(pc_sel), 32'd0);
    checkOutput("rf_t2_pc_tgt", pc_tgt, 32'h0);
    checkOutput("rf_t2_redir_cnt", 32'(redirect_cnt), 32'd0);
    checkOutput("rf_t2_stall_cnt", 32'(stall_cnt), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);           // T+3, stays in RUN
    checkCtl("rf_t3", 3'b111, 1'b0, 1'b0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
